// File: rtl/axis_noc_pkg.sv
// Shared AXI-Stream NoC types and header field layout, used by packetizers and router-side decoders.
package axis_noc_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned HDR_X_LSB   = 0;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HEADER  = 2'd2,
    ST_DRAIN   = 2'd3
  } pkt_state_e;

  // Field width for an index over n items; never zero so slices stay legal.
  function automatic int unsigned field_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Header layout: x at the bottom, then y, then payload length.
  function automatic int unsigned hdr_y_lsb(input int unsigned x_w);
    return HDR_X_LSB + x_w;
  endfunction

  function automatic int unsigned hdr_len_lsb(input int unsigned x_w, input int unsigned y_w);
    return HDR_X_LSB + x_w + y_w;
  endfunction

endpackage

// File: rtl/packetizer_buffer.sv
// Payload FIFO for one packet: written in arrival order, read out in the same order, cleared between packets.
module packetizer_buffer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_i) begin
        mem_d[wr_ptr_q] = wr_data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_en_i) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_data_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/router_local_packetizer.sv
// Turns a local node's message stream into NoC packets: header flit (target, length) plus up to
// MAX_PACKAGES buffered payload flits; long messages are split into several packets to the same target.
module router_local_packetizer
  import axis_noc_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned MAX_ROUTERS_X   = 4,
  parameter int unsigned MAX_ROUTERS_Y   = 4,
  parameter int unsigned MAX_PACKAGES    = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  axis_mosi_t                         in_mosi_i,
  output axis_miso_t                         in_miso_o,
  input  logic [field_w(MAX_ROUTERS_X)-1:0]  target_x_i,
  input  logic [field_w(MAX_ROUTERS_Y)-1:0]  target_y_i,
  output axis_mosi_t                         out_mosi_o,
  input  axis_miso_t                         out_miso_i
);

  localparam int unsigned DW      = AXIS_DATA_WIDTH;
  localparam int unsigned X_W     = field_w(MAX_ROUTERS_X);
  localparam int unsigned Y_W     = field_w(MAX_ROUTERS_Y);
  localparam int unsigned LEN_W   = $clog2(MAX_PACKAGES + 1);
  localparam int unsigned Y_LSB   = hdr_y_lsb(X_W);
  localparam int unsigned LEN_LSB = hdr_len_lsb(X_W, Y_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PACKAGES);

  pkt_state_e       state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] sent_q, sent_d;
  logic [X_W-1:0]   tgt_x_q, tgt_x_d;
  logic [Y_W-1:0]   tgt_y_q, tgt_y_d;
  logic             msg_end_q, msg_end_d;
  logic             in_tready_q, in_tready_d;
  logic             out_tvalid_q, out_tvalid_d;
  logic             out_tlast_q, out_tlast_d;
  logic [DW-1:0]    out_tdata_q, out_tdata_d;

  logic             in_hs;
  logic             out_hs;
  logic             buf_wr_en;
  logic             buf_rd_en;
  logic             buf_clr;
  logic [DW-1:0]    buf_rd_data;

  function automatic logic [DW-1:0] make_header(input logic [X_W-1:0]   x,
                                                 input logic [Y_W-1:0]   y,
                                                 input logic [LEN_W-1:0] len);
    logic [DW-1:0] h;
    h                    = '0;
    h[HDR_X_LSB +: X_W]  = x;
    h[Y_LSB +: Y_W]      = y;
    h[LEN_LSB +: LEN_W]  = len;
    return h;
  endfunction

  packetizer_buffer #(
    .DW    (DW),
    .DEPTH (MAX_PACKAGES)
  ) u_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr_en),
    .wr_data_i (DW'(in_mosi_i.tdata)),
    .rd_en_i   (buf_rd_en),
    .rd_data_c (buf_rd_data)
  );

  assign in_hs  = in_mosi_i.tvalid & in_tready_q;
  assign out_hs = out_tvalid_q & out_miso_i.tready;

  // Next-state and registered-output logic; output regs always hold the flit currently offered.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    sent_d       = sent_q;
    tgt_x_d      = tgt_x_q;
    tgt_y_d      = tgt_y_q;
    msg_end_d    = msg_end_q;
    out_tvalid_d = out_tvalid_q;
    out_tlast_d  = out_tlast_q;
    out_tdata_d  = out_tdata_q;
    buf_wr_en    = 1'b0;
    buf_rd_en    = 1'b0;
    buf_clr      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (in_hs) begin
          buf_wr_en = 1'b1;
          msg_end_d = in_mosi_i.tlast;
          if (state_q == ST_IDLE) begin
            tgt_x_d = target_x_i;
            tgt_y_d = target_y_i;
            count_d = LEN_W'(1);
            state_d = ST_COLLECT;
          end else begin
            count_d = count_q + LEN_W'(1);
          end
          if (in_mosi_i.tlast || (count_d == LEN_MAX)) begin
            state_d      = ST_HEADER;
            out_tvalid_d = 1'b1;
            out_tlast_d  = 1'b0;
            out_tdata_d  = make_header(tgt_x_d, tgt_y_d, count_d);
          end
        end
      end

      ST_HEADER: begin
        if (out_hs) begin
          state_d     = ST_DRAIN;
          buf_rd_en   = 1'b1;
          out_tdata_d = buf_rd_data;
          sent_d      = LEN_W'(1);
          out_tlast_d = (count_q == LEN_W'(1));
        end
      end

      ST_DRAIN: begin
        if (out_hs) begin
          if (out_tlast_q) begin
            // Packet done: either the message ended or the next chunk reuses the latched target.
            buf_clr      = 1'b1;
            out_tvalid_d = 1'b0;
            out_tlast_d  = 1'b0;
            out_tdata_d  = '0;
            count_d      = '0;
            sent_d       = '0;
            state_d      = msg_end_q ? ST_IDLE : ST_COLLECT;
          end else begin
            buf_rd_en   = 1'b1;
            out_tdata_d = buf_rd_data;
            sent_d      = sent_q + LEN_W'(1);
            out_tlast_d = (sent_d == count_q);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    in_tready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      sent_q       <= '0;
      tgt_x_q      <= '0;
      tgt_y_q      <= '0;
      msg_end_q    <= 1'b0;
      in_tready_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      out_tdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      sent_q       <= sent_d;
      tgt_x_q      <= tgt_x_d;
      tgt_y_q      <= tgt_y_d;
      msg_end_q    <= msg_end_d;
      in_tready_q  <= in_tready_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
      out_tdata_q  <= out_tdata_d;
    end
  end

  always_comb begin
    in_miso_o.tready  = in_tready_q;
    out_mosi_o.tvalid = out_tvalid_q;
    out_mosi_o.tlast  = out_tlast_q;
    out_mosi_o.tdata  = AXIS_DATA_W'(out_tdata_q);
  end

endmodule

// File: doc/router_local_packetizer.md
ROUTER_LOCAL_PACKETIZER -- requirements
Module: router_local_packetizer

Interface
REQ-001 The module SHALL have parameter AXIS_DATA_WIDTH, default 32, meaning TDATA width of all flits.
REQ-002 The module SHALL have parameter MAX_ROUTERS_X, default 4, meaning mesh width; X_W = $clog2(MAX_ROUTERS_X).
REQ-003 The module SHALL have parameter MAX_ROUTERS_Y, default 4, meaning mesh height; Y_W = $clog2(MAX_ROUTERS_Y).
REQ-004 The module SHALL have parameter MAX_PACKAGES, default 4, meaning maximum payload flits per packet; LEN_W = $clog2(MAX_PACKAGES+1).
REQ-005 Ports SHALL be: clk_i  input  1  single clock, rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 in_mosi_i  input  axis_mosi_t  payload stream from local node (TDATA, TVALID, TLAST used).
REQ-008 in_miso_o  output  axis_miso_t  TREADY to local node.
REQ-009 target_x_i  input  X_W  destination column, sampled with first flit of a message.
REQ-010 target_y_i  input  Y_W  destination row, sampled with first flit of a message.
REQ-011 out_mosi_o  output  axis_mosi_t  header+payload packets to router local input port.
REQ-012 out_miso_i  input  axis_miso_t  TREADY from router local input port.

Function
REQ-013 Message = input flits up to and including TLAST; packet = one header flit + 1..MAX_PACKAGES payload flits, last payload flit carries out TLAST=1.
REQ-014 Header TDATA: [X_W-1:0]=target_x, [X_W+Y_W-1:X_W]=target_y, next LEN_W bits = payload count, remaining bits 0; header TLAST=0.
REQ-015 FSM states: IDLE, COLLECT, HEADER, DRAIN.
REQ-016 IDLE: in TREADY=1; on in handshake latch target_x_i/target_y_i, write flit to buffer, count=1, go COLLECT (or HEADER if TLAST=1 or MAX_PACKAGES=1).
REQ-017 COLLECT: in TREADY=1; each handshake writes buffer, count+1; go HEADER when accepted flit has TLAST=1 or count reaches MAX_PACKAGES.
REQ-018 HEADER: out TVALID=1 with header; in TREADY=0; on out handshake go DRAIN.
REQ-019 DRAIN: out TVALID=1 with buffered flits in arrival order, TLAST=1 only on the count-th flit; in TREADY=0.
REQ-020 After last DRAIN handshake: go IDLE if message TLAST was seen, else COLLECT with count=0 and latched target retained.
REQ-021 Message longer than MAX_PACKAGES SHALL split into ceil(N/MAX_PACKAGES) packets, all with the same target; target_x_i/target_y_i changes mid-message SHALL be ignored.
REQ-022 out TVALID SHALL stay asserted and out TDATA/TLAST stable until out TREADY (AXIS rule); in TREADY SHALL not depend on out TREADY combinationally.
REQ-023 Latency: header TVALID first asserted the cycle after the closing input handshake.
REQ-024 Count arithmetic SHALL be LEN_W wide, never wrap; buffer SHALL never overflow (TREADY=0 outside IDLE/COLLECT).

Reset
REQ-025 While rst_i=1: state=IDLE, count=0, buffer pointers=0, latched target=0, out TVALID=0, out TLAST=0, out TDATA=0, in TREADY=0.
REQ-026 Reset asserted mid-packet SHALL discard buffered flits and partial packet; first cycle after release in TREADY=1.

Structure
REQ-027 axis_mosi_t/axis_miso_t and header field offset/width constants SHALL live in shared package axis_noc_pkg, reused by router-side decoding.
REQ-028 Payload storage SHALL be one sub-module packetizer_buffer (depth MAX_PACKAGES, write/read pointers, reset clear).

Verification
REQ-029 3-flit message A,B,C(TLAST), target (2,1), out TREADY=1 -> header {len=3,y=1,x=2}, A, B, C with TLAST on C only.
REQ-030 9-flit message, MAX_PACKAGES=4 -> three packets, headers len=4,4,1, identical target, TLAST on flits 4,8,9.
REQ-031 Single flit with TLAST -> header len=1 then flit TLAST=1; in TREADY low HEADER/DRAIN, high next IDLE cycle.
REQ-032 out TREADY random 30% duty -> output data/TLAST stable while stalled, no flit lost or duplicated, order preserved.
REQ-033 target_x_i changed 0->3 mid-message -> all packets of message keep original target; next message uses 3.
REQ-034 rst_i pulsed during DRAIN of second flit -> out TVALID=0 immediately, next message emits fresh header, no stale data.
